// File: rtl/dsn_neuron_sched.sv
// dsn_neuron_sched: one shared integrate/leak/fire datapath time-multiplexed
// across NUM_NEURONS virtual neurons. Synaptic events and periodic leak sweeps
// compete for the datapath. Leak sweeps always win over events.
module dsn_neuron_sched #(
  parameter int NUM_NEURONS = 4,
  parameter int VW          = 13,   // must be > WW
  parameter int WW          = 8,
  localparam int IW         = $clog2(NUM_NEURONS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [VW-1:0] vth,
  input  logic [WW-1:0] leak,
  input  logic          ev_valid,
  output logic          ev_ready,
  input  logic [IW-1:0] ev_idx,
  input  logic [WW-1:0] ev_weight,
  input  logic          leak_tick,
  output logic          spike,
  output logic [IW-1:0] spike_idx,
  output logic [VW-1:0] vfire,
  output logic          busy,
  output logic          leak_overrun,
  output logic [7:0]    sweep_count
);

  typedef enum logic [1:0] {IDLE, EV_UPD, LEAK} state_t;

  state_t        state;
  logic [VW-1:0] vmem [NUM_NEURONS];
  logic [IW-1:0] cur_idx;
  logic [WW-1:0] cur_weight;
  logic [IW-1:0] sweep_idx;
  logic          leak_pend;

  logic [VW:0]   sum_wide;
  logic [VW-1:0] sum_sat;
  logic [VW-1:0] leak_ext;
  logic [VW-1:0] leak_res;

  // Integrate and leak arithmetic for the neuron currently owning the datapath.
  // The extra sum bit catches overflow so the membrane saturates instead of wrapping.
  always_comb begin
    sum_wide = {1'b0, vmem[cur_idx]} + {{(VW + 1 - WW){1'b0}}, cur_weight};
    sum_sat  = sum_wide[VW] ? {VW{1'b1}} : sum_wide[VW-1:0];
    leak_ext = {{(VW - WW){1'b0}}, leak};
    leak_res = (vmem[sweep_idx] > leak_ext) ? (vmem[sweep_idx] - leak_ext) : '0;
  end

  // Events are refused while a tick is arriving or waiting, so leak keeps priority.
  assign ev_ready = (state == IDLE) && !leak_pend && !leak_tick;
  assign busy     = (state != IDLE);

  // Scheduler: arbitration, shared update sequencing and registered spike outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      for (int i = 0; i < NUM_NEURONS; i++) vmem[i] <= '0;
      cur_idx      <= '0;
      cur_weight   <= '0;
      sweep_idx    <= '0;
      leak_pend    <= 1'b0;
      leak_overrun <= 1'b0;
      sweep_count  <= '0;
      spike        <= 1'b0;
      spike_idx    <= '0;
      vfire        <= '0;
    end else begin
      spike <= 1'b0;

      // A tick arriving while busy is remembered once; a second one is lost.
      if (leak_tick && state != IDLE) begin
        if (leak_pend) leak_overrun <= 1'b1;
        else           leak_pend    <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (leak_tick || leak_pend) begin
            state     <= LEAK;
            sweep_idx <= '0;
            leak_pend <= 1'b0;
          end else if (ev_valid && ev_ready) begin
            cur_idx    <= ev_idx;
            cur_weight <= ev_weight;
            state      <= EV_UPD;
          end
        end
        EV_UPD: begin
          // Potential reported on a fire is the pre-reset (saturated) sum.
          if (sum_sat >= vth) begin
            spike         <= 1'b1;
            spike_idx     <= cur_idx;
            vfire         <= sum_sat;
            vmem[cur_idx] <= '0;
          end else begin
            vmem[cur_idx] <= sum_sat;
          end
          state <= IDLE;
        end
        LEAK: begin
          vmem[sweep_idx] <= leak_res;
          if (sweep_idx == IW'(NUM_NEURONS - 1)) begin
            state       <= IDLE;
            sweep_count <= sweep_count + 8'd1;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsn_neuron_sched.sv
// Bench for dsn_neuron_sched: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against an operation-level model.
module tb_dsn_neuron_sched;

  localparam int N    = 4;
  localparam int VW   = 13;
  localparam int WW   = 8;
  localparam int IW   = 2;
  localparam int VMAX = (1 << VW) - 1;

  logic          clock = 1'b0;
  logic          reset;
  logic [VW-1:0] vth;
  logic [WW-1:0] leak;
  logic          ev_valid;
  logic          ev_ready;
  logic [IW-1:0] ev_idx;
  logic [WW-1:0] ev_weight;
  logic          leak_tick;
  logic          spike;
  logic [IW-1:0] spike_idx;
  logic [VW-1:0] vfire;
  logic          busy;
  logic          leak_overrun;
  logic [7:0]    sweep_count;

  always #5 clock = ~clock;

  dsn_neuron_sched #(.NUM_NEURONS(N), .VW(VW), .WW(WW)) dut (
    .clock(clock), .reset(reset), .vth(vth), .leak(leak),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx), .ev_weight(ev_weight),
    .leak_tick(leak_tick), .spike(spike), .spike_idx(spike_idx), .vfire(vfire),
    .busy(busy), .leak_overrun(leak_overrun), .sweep_count(sweep_count)
  );

  int checks = 0;
  int errors = 0;

  // Model: potentials, remaining busy cycles of the current operation and its kind.
  int vm [N];
  int busy_left;
  int op_is_leak;
  int pend, ovr, sweeps;
  int cur_i, cur_w;
  bit e_spike;
  int e_idx, e_vfire;

  bit last_acc;
  bit obs_spike;
  int obs_idx, obs_vfire;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (busy_left == 0) && (pend == 0) && !leak_tick;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) vm[i] = 0;
    busy_left = 0; op_is_leak = 0; pend = 0; ovr = 0; sweeps = 0;
    e_spike = 0; e_idx = 0; e_vfire = 0;
  endtask

  // A sweep's effect is applied as a whole when it starts (leak is held steady
  // during sweeps); an event's effect is applied on the edge that completes it.
  task automatic model_edge(input bit acc);
    int s;
    e_spike = 0;
    if (busy_left == 0) begin
      if (leak_tick || pend != 0) begin
        pend = 0; op_is_leak = 1; busy_left = N;
        for (int i = 0; i < N; i++) vm[i] = (vm[i] > int'(leak)) ? vm[i] - int'(leak) : 0;
      end else if (acc) begin
        op_is_leak = 0; busy_left = 1; cur_i = int'(ev_idx); cur_w = int'(ev_weight);
      end
    end else begin
      if (leak_tick) begin
        if (pend != 0) ovr = 1;
        else           pend = 1;
      end
      if (op_is_leak == 0) begin
        s = vm[cur_i] + cur_w;
        if (s > VMAX) s = VMAX;
        if (s >= int'(vth)) begin
          e_spike = 1; e_idx = cur_i; e_vfire = s; vm[cur_i] = 0;
        end else begin
          vm[cur_i] = s;
        end
      end else if (busy_left == 1) begin
        sweeps = (sweeps + 1) % 256;
      end
      busy_left--;
    end
  endtask

  // One clock: check ready against the model, advance both, then check outputs.
  task automatic step();
    bit acc;
    #1;
    chk("ev_ready", ev_ready, m_ready());
    acc = ev_valid && m_ready();
    last_acc = acc;
    @(posedge clock);
    model_edge(acc);
    @(negedge clock);
    chk("spike", spike, e_spike);
    chk("busy", busy, busy_left != 0);
    chk("leak_overrun", leak_overrun, ovr);
    chk("sweep_count", sweep_count, sweeps);
    if (e_spike) begin
      chk("spike_idx", spike_idx, e_idx);
      chk("vfire", vfire, e_vfire);
    end
    obs_spike = spike; obs_idx = spike_idx; obs_vfire = vfire;
    $display("cyc t=%0t valid=%0b ready=%0b acc=%0b tick=%0b spike=%0b idx=%0d vfire=%0d busy=%0b sweeps=%0d",
             $time, ev_valid, ev_ready, acc, leak_tick, spike, spike_idx, vfire, busy, sweep_count);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Present an event, hold it until accepted (bounded), then run the update cycle.
  task automatic send_event(input int idx, input int w);
    bit done = 0;
    ev_valid = 1; ev_idx = IW'(idx); ev_weight = WW'(w);
    for (int n = 0; n < 40 && !done; n++) begin
      step();
      done = last_acc;
    end
    ev_valid = 0;
    chk("ev_accept", done, 1);
    step();
  endtask

  task automatic tick_once();
    leak_tick = 1;
    step();
    leak_tick = 0;
  endtask

  initial begin
    int sat_spikes;
    int acc_at;
    reset = 1; vth = 13'd32; leak = '0; ev_valid = 0; ev_idx = '0; ev_weight = '0; leak_tick = 0;
    model_reset();

    // Reset values
    @(negedge clock); #1;
    chk("rst_ev_ready", ev_ready, 1);
    chk("rst_spike", spike, 0);
    chk("rst_spike_idx", spike_idx, 0);
    chk("rst_vfire", vfire, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", leak_overrun, 0);
    chk("rst_sweep_count", sweep_count, 0);
    reset = 0;

    // Integrate then fire at exactly threshold
    send_event(1, 20);
    chk("if_nospike", obs_spike, 0);
    send_event(1, 12);
    chk("if_spike", obs_spike, 1);
    chk("if_idx", obs_idx, 1);
    chk("if_vfire", obs_vfire, 32);

    // Zero threshold fires on a zero-weight event
    vth = '0;
    send_event(3, 0);
    chk("vth0_spike", obs_spike, 1);
    chk("vth0_idx", obs_idx, 3);
    chk("vth0_vfire", obs_vfire, 0);
    vth = 13'd32;

    // Leak floor: 5 -> 3 -> 1 -> 0, then 29 + 3 must land exactly on 32
    leak = 8'd2;
    send_event(2, 5);
    repeat (3) begin
      tick_once();
      idle(6);
    end
    chk("leak_sweeps", sweep_count, 3);
    send_event(2, 29);
    chk("leak_nospike", obs_spike, 0);
    send_event(2, 3);
    chk("leak_spike", obs_spike, 1);
    chk("leak_vfire", obs_vfire, 32);

    // Saturation: 32*255 = 8160 stays below, the 33rd saturates at 8191 and fires
    vth = 13'd8191;
    sat_spikes = 0;
    for (int k = 1; k <= 33; k++) begin
      send_event(0, 255);
      if (k < 33) sat_spikes += int'(obs_spike);
    end
    chk("sat_early_spikes", sat_spikes, 0);
    chk("sat_spike", obs_spike, 1);
    chk("sat_vfire", obs_vfire, 8191);

    // Arbitration: tick and event together, event waits out the 4-cycle sweep
    vth = 13'd32;
    leak_tick = 1; ev_valid = 1; ev_idx = 2'd1; ev_weight = 8'd7;
    acc_at = -1;
    for (int n = 0; n < 20; n++) begin
      step();
      leak_tick = 0;
      if (last_acc) begin
        acc_at = n;
        break;
      end
    end
    ev_valid = 0;
    chk("arb_accept_step", acc_at, 5);
    step();

    // Overrun: two ticks inside one sweep, second one is lost
    tick_once();
    step();
    tick_once();
    tick_once();
    idle(12);
    chk("ovr_sweeps", sweep_count, 6);
    chk("ovr_flag", leak_overrun, 1);

    // Randomized traffic
    for (int r = 0; r < 400; r++) begin
      if ($urandom_range(0, 19) == 0) vth = VW'($urandom_range(0, 700));
      if (busy_left == 0 && $urandom_range(0, 19) == 0) leak = WW'($urandom_range(0, 60));
      leak_tick = ($urandom_range(0, 11) == 0);
      if (!ev_valid && $urandom_range(0, 2) == 0) begin
        ev_valid  = 1;
        ev_idx    = IW'($urandom_range(0, N - 1));
        ev_weight = WW'($urandom_range(0, 255));
      end
      step();
      if (last_acc) ev_valid = 0;
    end
    leak_tick = 0; ev_valid = 0;
    idle(8);

    // Reset in the middle of a sweep
    tick_once();
    step();
    step();
    reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_spike", spike, 0);
    chk("mid_rst_spike_idx", spike_idx, 0);
    chk("mid_rst_vfire", vfire, 0);
    chk("mid_rst_sweep_count", sweep_count, 0);
    chk("mid_rst_overrun", leak_overrun, 0);
    chk("mid_rst_ev_ready", ev_ready, 1);
    model_reset();
    #1;
    reset = 0;
    vth = 13'd32;
    send_event(0, 10);
    chk("post_rst_nospike", obs_spike, 0);
    send_event(0, 22);
    chk("post_rst_spike", obs_spike, 1);
    chk("post_rst_vfire", obs_vfire, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dsn_neuron_sched.md
# dsn_neuron_sched

Time-multiplexed scheduler that shares one integrate/leak/fire neuron datapath among NUM_NEURONS virtual neurons. It holds every membrane potential in an internal register array and arbitrates between two requesters: synaptic events (valid/ready) and periodic leak ticks. Each granted request is sequenced through the shared update, and the block emits one spike pulse per firing neuron with its index and pre-reset potential. It sits between the spike-event router and the downstream spike collector, in place of one DSN neuron instance per neuron.

## Interface
- NUM_NEURONS, 4: virtual neurons; power of two, ≥2; IW = log2(NUM_NEURONS)
- VW, 13: membrane and threshold width
- WW, 8: synaptic weight and leak width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- vth  in  VW  firing threshold, sampled live on every event update
- leak  in  WW  leak amount subtracted per tick, sampled live
- ev_valid  in  1  event request
- ev_ready  out  1  event accept
- ev_idx  in  IW  target neuron
- ev_weight  in  WW  unsigned weight
- leak_tick  in  1  one-cycle pulse requesting a leak sweep
- spike  out  1  one-cycle fire pulse, registered
- spike_idx  out  IW  firing neuron, valid with spike
- vfire  out  VW  potential at fire (pre-reset), valid with spike
- busy  out  1  state ≠ IDLE
- leak_overrun  out  1  sticky: tick lost
- sweep_count  out  8  completed leak sweeps, wraps 255→0

## Operation
- Storage: vmem[0..NUM_NEURONS-1], VW bits unsigned, all 0 at reset.
- States: IDLE, EV_UPD, LEAK.
- IDLE: if leak_tick or leak_pend → LEAK, sweep_idx=0, leak_pend cleared. Else if ev_valid && ev_ready → capture ev_idx/ev_weight, go to EV_UPD.
- ev_ready = (state==IDLE) && !leak_pend && !leak_tick (combinational). Leak has priority over events.
- EV_UPD (1 cycle): sum = vmem[idx] + weight, saturated at 2^VW−1. If sum ≥ vth: spike=1, spike_idx=idx, vfire=sum, vmem[idx]=0. Else vmem[idx]=sum, no spike. → IDLE.
- vth=0: every event fires (sum ≥ 0 always).
- LEAK (NUM_NEURONS cycles): vmem[sweep_idx] = (vmem > leak) ? vmem − leak : 0, with a floor of 0 and never negative. No spikes from leak. On the last index → IDLE, sweep_count += 1 (wraps).
- leak_tick during EV_UPD or LEAK: set leak_pend. If leak_pend is already 1, set leak_overrun (sticky until reset); the tick is dropped.
- Reset mid-operation: immediate abort. vmem, leak_pend, sweep_count, leak_overrun, spike, spike_idx, vfire cleared; state=IDLE.

## Timing
- Reset values: ev_ready=1 (IDLE, no tick), spike=0, spike_idx=0, vfire=0, busy=0, leak_overrun=0, sweep_count=0.
- Event accepted at edge T → EV_UPD during T+1 → spike/spike_idx/vfire visible T+2 for exactly one cycle. IDLE and ev_ready high again from T+2. Maximum throughput is one event per 2 cycles.
- Consecutive events to the same neuron see the previous write; there is no hazard.
- Tick seen in IDLE at T → LEAK during T+1..T+NUM_NEURONS. IDLE at T+NUM_NEURONS+1. sweep_count increments at that edge.
- Pending tick: LEAK starts the cycle after the current operation returns to IDLE. That IDLE cycle has ev_ready=0.
- ev_valid may stay asserted with ready low; idx/weight must be held until accepted.

## Test plan
- Integrate/fire (vth=32): event idx1 w=20 → no spike, vmem[1]=20. Event idx1 w=12 → spike 2 cycles after accept, spike_idx=1, vfire=32, vmem[1]=0.
- Leak floor (leak=2): vmem[2]=5, three ticks spaced ≥6 cycles → vmem[2]=3,1,0. Other neurons at 0 stay 0. sweep_count=3.
- Saturation (vth=8191): 33 events idx0 w=255 → vmem[0] caps at 8191 on event 33. Spike fires with vfire=8191, then vmem[0]=0.
- Arbitration: leak_tick and ev_valid asserted in same IDLE cycle → ev_ready=0, sweep runs 4 cycles, event accepted on cycle 5 after tick. Tick twice during one sweep → leak_overrun=1, exactly two sweeps run in total.
- vth=0: event w=0 on idx3 → spike, spike_idx=3, vfire=0.
- Reset mid-sweep: assert reset during LEAK cycle 2 → all outputs return to reset values asynchronously, vmem all 0. Next event w=10 to idx0 with vth=32 → vmem[0]=10, no spike.
